// File: rtl/kp_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package kp_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} kp_state_t;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam logic [3:0] ROW_IDLE = 4'hF;

    // Lowest-numbered row that is pulled low; only meaningful when rows != ROW_IDLE.
    function automatic logic [1:0] first_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter; max_tick is high for one clk every M clocks.
module mod_m_counter #(
    parameter int M = 10,
    parameter int N = (M > 1) ? $clog2(M) : 1
) (
    input  logic clk,
    input  logic rst,
    output logic max_tick
);

    logic [N-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (count == N'(M - 1))
            count <= '0;
        else
            count <= count + N'(1);
    end

    assign max_tick = (count == N'(M - 1));

endmodule

// File: rtl/keypad_scan_driver.sv
// 4x4 matrix keypad scanner: strobes active-low columns, debounces press and
// release on scan ticks, and reports the first detected key with a valid pulse.
//
// state    | meaning
// SCAN     | stepping columns one per tick, looking for any low row
// DEBOUNCE | column frozen, counting stable low ticks on the captured row
// PRESSED  | key accepted and held, counting idle ticks until release
module keypad_scan_driver
    import kp_pkg::*;
#(
    parameter int SCAN_DIV  = 200_000,
    parameter int DEB_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_TICKS);

    logic       tick;
    logic [3:0] row_m, row_s;

    kp_state_t  state, state_next;
    logic [1:0] col_idx, col_idx_next;
    logic [1:0] row_idx, row_idx_next;
    logic [3:0] cnt, cnt_next, cnt_inc;
    logic [3:0] col_next;
    logic [3:0] key_code_next;
    logic       key_valid_next;
    logic       key_held_next;

    mod_m_counter #(.M(SCAN_DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .max_tick (tick)
    );

    // rows are pulled up, so the synchroniser idles at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m <= ROW_IDLE;
            row_s <= ROW_IDLE;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            cnt       <= 4'd0;
            col       <= 4'b1110;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            col_idx   <= col_idx_next;
            row_idx   <= row_idx_next;
            cnt       <= cnt_next;
            col       <= col_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

    always_comb begin
        state_next     = state;
        col_idx_next   = col_idx;
        row_idx_next   = row_idx;
        cnt_next       = cnt;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        key_held_next  = key_held;
        cnt_inc        = cnt + 4'd1;

        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_s == ROW_IDLE) begin
                        col_idx_next = col_idx + 2'd1;
                    end else begin
                        row_idx_next = first_low(row_s);
                        if (DEB_LAST == 4'd1) begin
                            state_next     = PRESSED;
                            key_code_next  = {row_idx_next, col_idx};
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            cnt_next       = 4'd0;
                        end else begin
                            state_next = DEBOUNCE;
                            cnt_next   = 4'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!row_s[row_idx]) begin
                        if (cnt_inc == DEB_LAST) begin
                            state_next     = PRESSED;
                            key_code_next  = {row_idx, col_idx};
                            key_valid_next = 1'b1;
                            key_held_next  = 1'b1;
                            cnt_next       = 4'd0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        state_next   = SCAN;
                        cnt_next     = 4'd0;
                        col_idx_next = col_idx + 2'd1;
                    end
                end
                PRESSED: begin
                    // any low row, including a second key, restarts the release count
                    if (row_s == ROW_IDLE) begin
                        if (cnt_inc == DEB_LAST) begin
                            state_next    = SCAN;
                            key_held_next = 1'b0;
                            col_idx_next  = col_idx + 2'd1;
                            cnt_next      = 4'd0;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cnt_next = 4'd0;
                    end
                end
                default: begin
                    state_next   = SCAN;
                    col_idx_next = 2'd0;
                    cnt_next     = 4'd0;
                end
            endcase
        end

        col_next = ~(4'b0001 << col_idx_next);
    end

endmodule

// File: tb/tb_keypad_scan_driver.sv
// Directed bench for keypad_scan_driver with a tick-level behavioural model of
// the keypad scanner and a physical keypad model driving the row lines.
module tb_keypad_scan_driver;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    bit pressed [4][4];

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int ticks_done = 0;

    // model state: scan position, candidate row (-1 = none), stable-tick run
    int         edge_k;
    int         scan_col;
    int         cand_row;
    int         run;
    bit         holding;
    logic [3:0] exp_col, exp_code;
    logic       exp_valid, exp_held;
    logic [3:0] hist1, hist2;

    keypad_scan_driver #(.SCAN_DIV(SCAN_DIV), .DEB_TICKS(DEB_TICKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // a pressed key shorts its row to its column when that column is strobed
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && col[c] == 1'b0) row[r] = 1'b0;
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_zero(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        edge_k    = 0;
        scan_col  = 0;
        cand_row  = -1;
        run       = 0;
        holding   = 1'b0;
        exp_code  = 4'd0;
        exp_valid = 1'b0;
        exp_held  = 1'b0;
        exp_col   = 4'b1110;
        hist1     = 4'hF;
        hist2     = 4'hF;
    endtask

    task automatic model_accept();
        holding   = 1'b1;
        run       = 0;
        exp_code  = 4'(cand_row * 4 + scan_col);
        exp_valid = 1'b1;
        exp_held  = 1'b1;
    endtask

    task automatic model_tick(input logic [3:0] rs);
        if (holding) begin
            if (rs == 4'hF) begin
                run++;
                if (run == DEB_TICKS) begin
                    holding  = 1'b0;
                    exp_held = 1'b0;
                    cand_row = -1;
                    run      = 0;
                    scan_col = (scan_col + 1) % 4;
                end
            end else begin
                run = 0;
            end
        end else if (cand_row >= 0) begin
            if (!rs[cand_row]) begin
                run++;
                if (run == DEB_TICKS) model_accept();
            end else begin
                cand_row = -1;
                run      = 0;
                scan_col = (scan_col + 1) % 4;
            end
        end else if (rs == 4'hF) begin
            scan_col = (scan_col + 1) % 4;
        end else begin
            cand_row = first_zero(rs);
            run      = 1;
            if (run == DEB_TICKS) model_accept();
        end
    endtask

    // compare, then predict the effect of the coming rising edge
    always @(negedge clk) begin
        if (rst) model_reset();
        check4("col", col, exp_col);
        check4("key_code", key_code, exp_code);
        check4("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
        check4("key_held", {3'b000, key_held}, {3'b000, exp_held});
        if (key_valid) pulses++;
        if (!rst) begin
            edge_k++;
            exp_valid = 1'b0;
            if (edge_k % SCAN_DIV == 0) begin
                model_tick(hist2);
                ticks_done++;
            end
            exp_col = 4'hF;
            exp_col[scan_col] = 1'b0;
            hist2 = hist1;
            hist1 = row;
        end
    end

    task automatic wait_ticks(input int n);
        int t0;
        int guard;
        t0 = ticks_done;
        guard = 0;
        while (ticks_done < t0 + n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) begin
            checks++;
            errors++;
            $display("FAIL wait_ticks: got %0d ticks expected %0d", ticks_done - t0, n);
        end
    endtask

    task automatic wait_held(input logic target, input int max_cyc);
        int cyc;
        cyc = 0;
        while (exp_held !== target && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check4("wait_held", {3'b000, exp_held}, {3'b000, target});
    endtask

    task automatic wait_col(input logic [3:0] target, input int max_cyc);
        int cyc;
        cyc = 0;
        while (exp_col !== target && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check4("wait_col", exp_col, target);
    endtask

    task automatic wait_debounce_run(input int n, input int max_cyc);
        int cyc;
        cyc = 0;
        while (!(cand_row >= 0 && !holding && run == n) && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc >= max_cyc) begin
            errors++;
            $display("FAIL wait_debounce: got run %0d expected %0d", run, n);
        end
    endtask

    initial begin
        logic [3:0] seq [4];
        int p0;
        seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // power-on reset
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check4("por_col", col, 4'b1110);
        check4("por_code", key_code, 4'd0);
        check4("por_valid", {3'b000, key_valid}, 4'd0);
        check4("por_held", {3'b000, key_held}, 4'd0);
        rst = 1'b0;

        // reset mid-scan, then one column step per tick
        wait_ticks(2);
        check4("midscan_col", col, 4'b1011);
        rst = 1'b1;
        #1;
        check4("rst_col", col, 4'b1110);
        check4("rst_valid", {3'b000, key_valid}, 4'd0);
        check4("rst_held", {3'b000, key_held}, 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check4("rst_rel_col", col, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            wait_ticks(1);
            check4("scan_seq", col, seq[i]);
        end

        // clean press of row 2 / column 1
        p0 = pulses;
        pressed[2][1] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        pressed[2][1] = 1'b0;
        check4("clean_pulses", 4'(pulses - p0), 4'd1);
        check4("clean_code", key_code, 4'b1001);
        check4("clean_held", {3'b000, key_held}, 4'd1);
        wait_held(1'b0, 60);
        check4("clean_rel_held", {3'b000, key_held}, 4'd0);
        check4("clean_rel_col", col, 4'b1011);
        check4("clean_code_kept", key_code, 4'b1001);

        // one-tick bounce on row 0 / column 3
        wait_col(4'b0111, 40);
        p0 = pulses;
        pressed[0][3] = 1'b1;
        wait_ticks(1);
        pressed[0][3] = 1'b0;
        wait_ticks(1);
        check4("bounce_col", col, 4'b1110);
        check4("bounce_pulses", 4'(pulses - p0), 4'd0);
        check4("bounce_held", {3'b000, key_held}, 4'd0);

        // release bounce on row 1 / column 2
        p0 = pulses;
        pressed[1][2] = 1'b1;
        wait_held(1'b1, 80);
        wait_ticks(2);
        pressed[1][2] = 1'b0;
        wait_ticks(2);
        pressed[1][2] = 1'b1;
        wait_ticks(1);
        pressed[1][2] = 1'b0;
        wait_ticks(2);
        check4("relb_held_mid", {3'b000, key_held}, 4'd1);
        wait_ticks(1);
        check4("relb_held_end", {3'b000, key_held}, 4'd0);
        check4("relb_pulses", 4'(pulses - p0), 4'd1);
        check4("relb_code", key_code, 4'b0110);

        // two keys in column 0: lowest row wins
        p0 = pulses;
        pressed[1][0] = 1'b1;
        pressed[3][0] = 1'b1;
        wait_held(1'b1, 80);
        repeat (2) @(posedge clk);
        #1;
        check4("two_code", key_code, 4'b0100);
        check4("two_held", {3'b000, key_held}, 4'd1);
        pressed[1][0] = 1'b0;
        pressed[3][0] = 1'b0;
        wait_held(1'b0, 80);
        check4("two_pulses", 4'(pulses - p0), 4'd1);

        // reset during debounce, then a fresh debounce from zero
        p0 = pulses;
        pressed[2][2] = 1'b1;
        wait_debounce_run(2, 80);
        rst = 1'b1;
        #1;
        check4("deb_rst_col", col, 4'b1110);
        check4("deb_rst_code", key_code, 4'd0);
        check4("deb_rst_valid", {3'b000, key_valid}, 4'd0);
        check4("deb_rst_pulses", 4'(pulses - p0), 4'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_held(1'b1, 80);
        repeat (2) @(posedge clk);
        #1;
        check4("deb_again_pulses", 4'(pulses - p0), 4'd1);
        check4("deb_again_code", key_code, 4'b1010);
        pressed[2][2] = 1'b0;
        wait_held(1'b0, 80);
        check4("deb_final_pulses", 4'(pulses - p0), 4'd1);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
